// File: rtl/binarization_multi_if.sv
// binarization_multi_if: grey-memory read port and binary-frame write port of the binarization engine.
interface binarization_multi_if #(
  parameter int PIX_W    = 8,
  parameter int LOG2_PIX = 16
) ();
  logic [LOG2_PIX-1:0] pixel_address;
  logic                pixel_rd;
  logic [PIX_W-1:0]    pixel_data;
  logic                bin_data;
  logic                bin_valid;
  logic [LOG2_PIX-1:0] bin_address;
  modport master (output pixel_address, pixel_rd, bin_data, bin_valid, bin_address, input pixel_data);
  modport slave (input pixel_address, pixel_rd, bin_data, bin_valid, bin_address, output pixel_data);
endinterface

// File: rtl/binarization_multi.sv
// binarization_multi: streams a grey frame from pixel memory into a binary frame using
// fixed, inverted, band or two-pass mean-adaptive thresholds.
module binarization_multi #(
  parameter int PIX_W    = 8,
  parameter int LOG2_PIX = 16,
  parameter int RD_LAT   = 1
) (
  input  logic                bin_clk,
  input  logic                bin_rst_n,
  input  logic                int_ctrl,
  input  logic                bin_ctrl,
  input  logic [1:0]          mode,
  input  logic [PIX_W-1:0]    thres_length,
  input  logic [PIX_W-1:0]    thres_high,
  binarization_multi_if.master bus,
  output logic [LOG2_PIX:0]   ones_count,
  output logic [PIX_W-1:0]    mean_thr,
  output logic                done,
  output logic                busy,
  output logic [1:0]          condition_led
);
  localparam logic [2:0] S_IDLE = 3'd0, S_SUM = 3'd1, S_CALC = 3'd2, S_BIN = 3'd3, S_DRAIN = 3'd4, S_DONE = 3'd5;
  localparam logic [LOG2_PIX-1:0] LAST = '1;
  localparam int SW = PIX_W + LOG2_PIX;
  logic [2:0] state_q, state_d;
  logic ctrl_q, ctrl_d, start_q, start_d, rd_q, rd_d, bin_valid_q, bin_valid_d, bin_data_q, bin_data_d, done_q, done_d;
  logic [1:0] mode_q, mode_d;
  logic [PIX_W-1:0] lo_q, lo_d, hi_q, hi_d, mean_q, mean_d;
  logic [LOG2_PIX-1:0] addr_q, addr_d, ret_cnt_q, ret_cnt_d, bin_addr_q, bin_addr_d;
  logic [LOG2_PIX:0] ones_q, ones_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic ret, hit;
  logic [PIX_W-1:0] p;
  assign p = bus.pixel_data;
  // pipe_q tracks which cycles carry a returned pixel, RD_LAT cycles after each read
  assign ret = pipe_q[RD_LAT-1];
  assign hit = mode_q == 2'b00 ? p >= lo_q :
               mode_q == 2'b01 ? p < lo_q :
               mode_q == 2'b10 ? (p >= lo_q && p <= hi_q) : p >= mean_q;
  always_comb begin
    ctrl_d      = bin_ctrl;
    start_d     = bin_ctrl & ~ctrl_q & ~int_ctrl;
    state_d     = state_q;
    mode_d      = mode_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    sum_d       = sum_q;
    mean_d      = mean_q;
    ret_cnt_d   = ret ? ret_cnt_q + 1'b1 : ret_cnt_q;
    bin_data_d  = bin_data_q;
    bin_addr_d  = bin_addr_q;
    bin_valid_d = 1'b0;
    ones_d      = ones_q;
    done_d      = 1'b0;
    pipe_d      = '0;
    pipe_d[0]   = rd_q;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
    if (rd_q) begin
      if (addr_q == LAST) rd_d = 1'b0;
      else addr_d = addr_q + 1'b1;
    end
    if (state_q == S_SUM && ret) begin
      sum_d = sum_q + SW'(p);
      if (ret_cnt_q == LAST) state_d = S_CALC;
    end
    if ((state_q == S_BIN || state_q == S_DRAIN) && ret) begin
      bin_valid_d = 1'b1;
      bin_data_d  = hit;
      bin_addr_d  = ret_cnt_q;
      ones_d      = ones_q + (LOG2_PIX+1)'(hit);
    end
    if (state_q == S_BIN && rd_q && addr_q == LAST) state_d = S_DRAIN;
    if (state_q == S_DRAIN && bin_valid_q && bin_addr_q == LAST) begin
      done_d  = 1'b1;
      state_d = S_DONE;
    end
    if (state_q == S_CALC) begin
      mean_d  = sum_q[SW-1:LOG2_PIX];
      state_d = S_BIN;
      addr_d  = '0;
      rd_d    = 1'b1;
    end
    if (start_q && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d   = mode == 2'b11 ? S_SUM : S_BIN;
      mode_d    = mode;
      lo_d      = thres_length;
      hi_d      = thres_high;
      addr_d    = '0;
      rd_d      = 1'b1;
      sum_d     = '0;
      mean_d    = '0;
      ones_d    = '0;
      ret_cnt_d = '0;
    end
    if (int_ctrl) begin
      state_d     = S_IDLE;
      mode_d      = '0;
      lo_d        = '0;
      hi_d        = '0;
      addr_d      = '0;
      rd_d        = 1'b0;
      sum_d       = '0;
      mean_d      = '0;
      ret_cnt_d   = '0;
      bin_data_d  = 1'b0;
      bin_addr_d  = '0;
      bin_valid_d = 1'b0;
      ones_d      = '0;
      done_d      = 1'b0;
      pipe_d      = '0;
    end
  end
  always_ff @(posedge bin_clk or negedge bin_rst_n) begin
    if (!bin_rst_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= 1'b0;
      start_q     <= 1'b0;
      mode_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      sum_q       <= '0;
      mean_q      <= '0;
      ret_cnt_q   <= '0;
      bin_data_q  <= 1'b0;
      bin_addr_q  <= '0;
      bin_valid_q <= 1'b0;
      ones_q      <= '0;
      done_q      <= 1'b0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      start_q     <= start_d;
      mode_q      <= mode_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      sum_q       <= sum_d;
      mean_q      <= mean_d;
      ret_cnt_q   <= ret_cnt_d;
      bin_data_q  <= bin_data_d;
      bin_addr_q  <= bin_addr_d;
      bin_valid_q <= bin_valid_d;
      ones_q      <= ones_d;
      done_q      <= done_d;
      pipe_q      <= pipe_d;
    end
  end
  assign bus.pixel_address = addr_q;
  assign bus.pixel_rd      = rd_q;
  assign bus.bin_data      = bin_data_q;
  assign bus.bin_valid     = bin_valid_q;
  assign bus.bin_address   = bin_addr_q;
  assign ones_count        = ones_q;
  assign mean_thr          = mean_q;
  assign done              = done_q;
  assign busy              = state_q != S_IDLE && state_q != S_DONE;
  assign condition_led     = state_q == S_IDLE ? 2'b00 :
                             (state_q == S_SUM || state_q == S_CALC) ? 2'b01 :
                             state_q == S_DONE ? 2'b11 : 2'b10;
endmodule

// File: tb/tb_binarization_multi.sv
// tb_binarization_multi: directed frames on an N=16 ramp image (pixel = 16*k), RD_LAT 1 and 3.
module tb_binarization_multi;
  logic clk = 0, rst_n = 0, int_ctrl = 0, bin_ctrl = 0;
  logic [1:0] mode = 0;
  logic [7:0] thr_lo = 0, thr_hi = 0;
  logic [4:0] ones, ones3;
  logic [7:0] mean, mean3;
  logic done, done3, busy, busy3;
  logic [1:0] led, led3;
  int checks = 0, failures = 0, cyc = 0, e;
  logic [15:0] bits, bits3;
  int nvalid, first_v, last_v, done_at, ndone, nrd, first_rd, first_v3, done_at3;
  logic addr_ok;
  logic [1:0] led1;
  logic [27:0] snap;
  logic [7:0] m1, m2;

  binarization_multi_if #(.PIX_W(8), .LOG2_PIX(4)) bus ();
  binarization_multi_if #(.PIX_W(8), .LOG2_PIX(4)) bus3 ();

  binarization_multi #(.PIX_W(8), .LOG2_PIX(4), .RD_LAT(1)) dut (
    .bin_clk(clk), .bin_rst_n(rst_n), .int_ctrl(int_ctrl), .bin_ctrl(bin_ctrl), .mode(mode),
    .thres_length(thr_lo), .thres_high(thr_hi), .bus(bus), .ones_count(ones), .mean_thr(mean),
    .done(done), .busy(busy), .condition_led(led));
  binarization_multi #(.PIX_W(8), .LOG2_PIX(4), .RD_LAT(3)) dut3 (
    .bin_clk(clk), .bin_rst_n(rst_n), .int_ctrl(int_ctrl), .bin_ctrl(bin_ctrl), .mode(mode),
    .thres_length(thr_lo), .thres_high(thr_hi), .bus(bus3), .ones_count(ones3), .mean_thr(mean3),
    .done(done3), .busy(busy3), .condition_led(led3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.pixel_data <= {bus.pixel_address, 4'b0000};
  always @(posedge clk) begin
    m1 <= {bus3.pixel_address, 4'b0000};
    m2 <= m1;
    bus3.pixel_data <= m2;
  end

  // hold: cycles bin_ctrl stays high; p2: rel cycle of a second pulse; int_at: -1 with start, >=0 at rel cycle
  task automatic capture(input int hold, input int p2, input int int_at, input int ncyc);
    int rel;
    bits = 0; bits3 = 0; nvalid = 0; first_v = -1; last_v = -1; done_at = -1; ndone = 0;
    nrd = 0; first_rd = -1; first_v3 = -1; done_at3 = -1; addr_ok = 1; led1 = 0; snap = '1;
    @(negedge clk);
    bin_ctrl = 1;
    if (int_at == -1) int_ctrl = 1;
    e = cyc + 1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rel = cyc - e;
      if (i + 1 >= hold) bin_ctrl = 0;
      if (p2 >= 0 && rel == p2) bin_ctrl = 1;
      int_ctrl = (rel == int_at);
      if (rel == 1) led1 = led;
      if (int_at >= 0 && rel == int_at + 1)
        snap = {busy, led, bus.pixel_rd, bus.bin_valid, bus.bin_data, done, ones, bus.pixel_address, bus.bin_address, mean};
      if (bus.pixel_rd) begin
        if (first_rd < 0) first_rd = rel;
        if (bus.pixel_address != 4'(nrd)) addr_ok = 0;
        nrd++;
      end
      if (bus.bin_valid) begin
        if (first_v < 0) first_v = rel;
        if (bus.bin_address != 4'(nvalid)) addr_ok = 0;
        bits[bus.bin_address] = bus.bin_data;
        nvalid++;
        last_v = rel;
      end
      if (bus3.bin_valid) begin
        if (first_v3 < 0) first_v3 = rel;
        bits3[bus3.bin_address] = bus3.bin_data;
      end
      if (done) begin ndone++; if (done_at < 0) done_at = rel; end
      if (done3 && done_at3 < 0) done_at3 = rel;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if ({busy, led, bus.pixel_rd, bus.bin_valid, done} !== 6'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0", {busy, led, bus.pixel_rd, bus.bin_valid, done}); end
    checks++; if ({ones, mean, bus.pixel_address, bus.bin_address, bus.bin_data} !== 22'b0) begin failures++; $display("FAIL reset_data got=%h exp=0", {ones, mean, bus.pixel_address, bus.bin_address, bus.bin_data}); end
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed;
    mode = 2'b00; thr_lo = 40; thr_hi = 0;
    capture(1, -1, -2, 45);
    checks++; if (bits !== 16'hFFF8) begin failures++; $display("FAIL fixed_bits got=%h exp=fff8", bits); end
    checks++; if (ones !== 5'd13) begin failures++; $display("FAIL fixed_ones got=%0d exp=13", ones); end
    checks++; if (first_rd != 1 || nrd != 16 || !addr_ok) begin failures++; $display("FAIL fixed_reads first=%0d n=%0d ok=%0d exp 1 16 1", first_rd, nrd, addr_ok); end
    checks++; if (first_v != 3) begin failures++; $display("FAIL fixed_first_valid got=%0d exp=3", first_v); end
    checks++; if (nvalid != 16 || last_v - first_v != 15) begin failures++; $display("FAIL fixed_valid_run n=%0d span=%0d exp 16 15", nvalid, last_v - first_v); end
    checks++; if (done_at != 19 || ndone != 1) begin failures++; $display("FAIL fixed_done at=%0d n=%0d exp 19 1", done_at, ndone); end
    checks++; if (led1 !== 2'b10) begin failures++; $display("FAIL fixed_led_bin got=%b exp=10", led1); end
    checks++; if (led !== 2'b11 || busy !== 1'b0 || mean !== 8'd0) begin failures++; $display("FAIL fixed_hold led=%b busy=%b mean=%0d exp 11 0 0", led, busy, mean); end
    checks++; if (first_v3 != 5 || done_at3 != 21) begin failures++; $display("FAIL lat3_timing first=%0d done=%0d exp 5 21", first_v3, done_at3); end
    checks++; if (bits3 !== 16'hFFF8 || ones3 !== 5'd13 || led3 !== 2'b11 || busy3 !== 1'b0) begin failures++; $display("FAIL lat3_frame bits=%h ones=%0d led=%b busy=%b exp fff8 13 11 0", bits3, ones3, led3, busy3); end
  endtask

  task automatic test_inverted;
    mode = 2'b01; thr_lo = 40;
    capture(1, -1, -2, 45);
    checks++; if (bits !== 16'h0007) begin failures++; $display("FAIL inv_bits got=%h exp=0007", bits); end
    checks++; if (ones !== 5'd3 || done_at != 19) begin failures++; $display("FAIL inv_ones got=%0d done=%0d exp 3 19", ones, done_at); end
  endtask

  task automatic test_band;
    mode = 2'b10; thr_lo = 64; thr_hi = 128;
    capture(1, -1, -2, 45);
    checks++; if (bits !== 16'h01F0) begin failures++; $display("FAIL band_bits got=%h exp=01f0", bits); end
    checks++; if (ones !== 5'd5) begin failures++; $display("FAIL band_ones got=%0d exp=5", ones); end
    thr_lo = 200; thr_hi = 100;
    capture(1, -1, -2, 45);
    checks++; if (bits !== 16'h0000 || nvalid != 16) begin failures++; $display("FAIL band_empty bits=%h n=%0d exp 0000 16", bits, nvalid); end
    checks++; if (ones !== 5'd0 || ndone != 1) begin failures++; $display("FAIL band_empty_ones got=%0d done=%0d exp 0 1", ones, ndone); end
  endtask

  task automatic test_mean(input string tag);
    mode = 2'b11; thr_lo = 0; thr_hi = 0;
    capture(1, -1, -2, 45);
    checks++; if (mean !== 8'd120 || mean3 !== 8'd120) begin failures++; $display("FAIL %s_mean got=%0d/%0d exp=120", tag, mean, mean3); end
    checks++; if (bits !== 16'hFF00 || ones !== 5'd8) begin failures++; $display("FAIL %s_bits bits=%h ones=%0d exp ff00 8", tag, bits, ones); end
    checks++; if (first_v != 21 || done_at != 37 || ndone != 1) begin failures++; $display("FAIL %s_timing first=%0d done=%0d n=%0d exp 21 37 1", tag, first_v, done_at, ndone); end
    checks++; if (nrd != 32 || !addr_ok || led1 !== 2'b01) begin failures++; $display("FAIL %s_passes rd=%0d ok=%0d led=%b exp 32 1 01", tag, nrd, addr_ok, led1); end
    checks++; if (done_at3 != 41 || bits3 !== 16'hFF00) begin failures++; $display("FAIL %s_lat3 done=%0d bits=%h exp 41 ff00", tag, done_at3, bits3); end
  endtask

  task automatic test_hold_start;
    mode = 2'b00; thr_lo = 40;
    capture(10, -1, -2, 45);
    checks++; if (ndone != 1 || nrd != 16 || nvalid != 16) begin failures++; $display("FAIL hold_one_frame done=%0d rd=%0d valid=%0d exp 1 16 16", ndone, nrd, nvalid); end
  endtask

  task automatic test_busy_edge;
    mode = 2'b00; thr_lo = 40;
    capture(1, 5, -2, 45);
    checks++; if (ndone != 1 || nrd != 16 || done_at != 19) begin failures++; $display("FAIL busy_edge done=%0d rd=%0d at=%0d exp 1 16 19", ndone, nrd, done_at); end
  endtask

  task automatic test_abort;
    mode = 2'b00; thr_lo = 40;
    capture(1, -1, 6, 30);
    checks++; if (snap !== 28'b0) begin failures++; $display("FAIL abort_outputs got=%h exp=0", snap); end
    checks++; if (ndone != 0 || nrd != 6 || nvalid != 4) begin failures++; $display("FAIL abort_activity done=%0d rd=%0d valid=%0d exp 0 6 4", ndone, nrd, nvalid); end
    checks++; if (busy !== 1'b0 || led !== 2'b00) begin failures++; $display("FAIL abort_idle busy=%b led=%b exp 0 00", busy, led); end
    capture(1, -1, -1, 25);
    checks++; if (nrd != 0 || ndone != 0 || nvalid != 0 || led !== 2'b00) begin failures++; $display("FAIL abort_with_start rd=%0d done=%0d valid=%0d led=%b exp 0 0 0 00", nrd, ndone, nvalid, led); end
  endtask

  task automatic test_async_reset;
    mode = 2'b11; thr_lo = 0;
    @(negedge clk); bin_ctrl = 1;
    @(negedge clk); bin_ctrl = 0;
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b1 || led !== 2'b01) begin failures++; $display("FAIL rst_pre_sum busy=%b led=%b exp 1 01", busy, led); end
    #2 rst_n = 0;
    #1;
    checks++; if ({busy, led, bus.pixel_rd, bus.pixel_address, ones, mean, done, bus.bin_valid} !== 24'b0) begin failures++; $display("FAIL rst_async got=%h exp=0", {busy, led, bus.pixel_rd, bus.pixel_address, ones, mean, done, bus.bin_valid}); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_inverted();
    test_band();
    test_mean("mean");
    test_hold_start();
    test_busy_edge();
    test_abort();
    test_async_reset();
    test_mean("after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/binarization_multi.md
# binarization_multi

Parametrised successor to the single-threshold binarization engine. It scans a grey-scale frame held in an external synchronous-read pixel memory and emits one binary pixel per cycle, with a write address, for the binary frame buffer. It adds configurable pixel width, frame size and memory read latency, plus four threshold modes, one of which is a two-pass mean-adaptive mode. It sits between the grey frame buffer and the binary frame buffer and is controlled by the same `int_ctrl`/`bin_ctrl` pushbutton-style inputs.

## Interface
- `PIX_W`, 8: pixel width in bits.
- `LOG2_PIX`, 16: log2 of frame size. `N = 2**LOG2_PIX` pixels.
- `RD_LAT`, 1: pixel memory read latency in cycles, range 1..4.
- `bin_clk` in 1: clock, rising edge.
- `bin_rst_n` in 1: asynchronous active-low reset.
- `int_ctrl` in 1: synchronous abort/initialise, level.
- `bin_ctrl` in 1: start. Acts on its rising edge; may be held high for any number of cycles.
- `mode` in 2: 00 fixed, 01 inverted, 10 band, 11 mean-adaptive. Latched at start.
- `thres_length` in PIX_W: low threshold. Latched at start.
- `thres_high` in PIX_W: high threshold, used only by band mode. Latched at start.
- `pixel_address` out LOG2_PIX: read address to the grey memory.
- `pixel_rd` out 1: read enable qualifying `pixel_address`.
- `pixel_data` in PIX_W: read data, valid RD_LAT cycles after the address.
- `bin_data` out 1: binary pixel.
- `bin_valid` out 1: qualifies `bin_data` and `bin_address`.
- `bin_address` out LOG2_PIX: write address of `bin_data`.
- `ones_count` out LOG2_PIX+1: number of 1 pixels in the last frame.
- `mean_thr` out PIX_W: mean computed in mode 11, otherwise 0.
- `done` out 1: one-cycle pulse at end of frame.
- `busy` out 1: high in every state except IDLE and DONE_HOLD.
- `condition_led` out 2: 00 idle, 01 sum pass, 10 binarize pass, 11 finished.

## Operation
- **States.** IDLE, SUM, CALC, BIN, DRAIN, DONE_HOLD.
- **Start.** The start event is a rising edge of `bin_ctrl`, detected from a registered copy. It is honoured only in IDLE or DONE_HOLD and ignored while busy.
- **On start:**
  - latch `mode`, `thres_length` and `thres_high`;
  - clear `ones_count`, `mean_thr` and the accumulator;
  - go to SUM if mode is 11, otherwise go to BIN.
- **SUM.**
  - Issue addresses 0..N-1, one per cycle.
  - Add each returned pixel into a sum of PIX_W+LOG2_PIX bits; this width never overflows.
  - After the last return, go to CALC.
- **CALC.** One cycle: `mean_thr` = sum >> LOG2_PIX (truncating). Then go to BIN.
- **BIN.**
  - Issue addresses 0..N-1, one per cycle.
  - Each returned pixel p produces `bin_data`:
    - mode 00: p >= thr_lo;
    - mode 01: p < thr_lo;
    - mode 10: thr_lo <= p <= thr_hi, which gives all 0 when thr_lo > thr_hi;
    - mode 11: p >= `mean_thr`.
  - `bin_address` equals the pixel's read address.
  - `ones_count` increments on each valid 1.
- **DRAIN.** Entered after the last address has been issued. Waits for the outstanding returns; after the last output, `done` pulses and the FSM enters DONE_HOLD.
- **DONE_HOLD.** `condition_led` = 11. Outputs other than `done`, `bin_valid` and `pixel_rd` hold. A new start is accepted here.
- **`int_ctrl` high.** Synchronously forces IDLE, clears every output, and discards returns in flight. It has priority over a start in the same cycle.
- **Reset.** Every output and every state register goes to 0 and the FSM goes to IDLE.

## Timing
- Let E be the clock edge at which the `bin_ctrl` rising edge is detected, and let cycle c be the interval after edge c.
- **Modes 00–10:**
  - `pixel_address` = k with `pixel_rd` = 1 in cycle E+1+k, for k = 0..N-1;
  - `pixel_data` for k arrives in cycle E+1+k+RD_LAT;
  - `bin_valid`/`bin_data`/`bin_address` for k are registered and appear in cycle E+2+k+RD_LAT;
  - `done` is high in cycle E+2+N+RD_LAT.
- **Mode 11:**
  - SUM addresses occupy cycles E+1..E+N;
  - CALC occupies cycle E+N+RD_LAT+1, and `mean_thr` is visible from the next cycle;
  - all BIN timings above shift by D = N+RD_LAT+1.
- **Continuity.** `pixel_rd` is continuous within a pass with no bubbles. `bin_valid` is continuous for N cycles.
- **Address wrap.** The address counter must not wrap: at N-1 it stops and `pixel_rd` drops.
- **Reset mid-run.** All outputs go to 0 immediately (asynchronously). No `done` is produced for the interrupted frame.

## Test plan
Bench settings: LOG2_PIX=4 (N=16), PIX_W=8, RD_LAT=1; memory model returns pixel = 16·k.
- **Mode 00, thres_length=40:** `bin_data` = 0,0,0 then 13 ones; `ones_count`=13; first `bin_valid` in cycle E+3; `done` in cycle E+19.
- **Mode 01, thres_length=40:** 3 ones (k=0..2); `ones_count`=3.
- **Mode 10:**
  - lo=64, hi=128: ones at k=4..8, `ones_count`=5;
  - lo=200, hi=100: all zeros, `ones_count`=0.
- **Mode 11:** sum=1920, `mean_thr`=120; ones at k=8..15, `ones_count`=8; `done` in cycle E+37.
- **Control:**
  - `bin_ctrl` held high for 10 cycles: exactly one frame;
  - second edge while busy: ignored;
  - `int_ctrl` at k=5: IDLE next cycle, outputs 0, no `done`;
  - `int_ctrl` and start together: stays IDLE.
- **Latency and reset:**
  - RD_LAT=3, mode 00: first `bin_valid` in cycle E+5;
  - `bin_rst_n` low mid-SUM: all outputs 0 asynchronously; after release a fresh start completes normally.
